// File: rtl/acc_core_ctl.sv
// acc_core_ctl: single-issue accumulator core (R0 = accumulator) with a req/done
// run-control FSM and a saturating run-cycle counter.
module acc_core_ctl #(
    parameter int DW       = 8,
    parameter int PW       = 12,
    parameter int PROG_END = 100,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    output logic [PW-1:0] instr_addr,
    input  logic [8:0]    instr,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [4:0]    lut_idx,
    input  logic [PW-1:0] lut_target,
    output logic [CW-1:0] cycle_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [3:0] OP_LD = 4'd0, OP_ST = 4'd1, OP_MOVT = 4'd2, OP_MOVF = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4, OP_SUB = 4'd5, OP_AND = 4'd6, OP_OR = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8, OP_SHL = 4'd9, OP_SHR = 4'd10, OP_LI = 4'd11;
    localparam logic [3:0] OP_ADDI = 4'd12, OP_BF = 4'd13, OP_JMP = 4'd14, OP_HALT = 4'd15;

    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [DW-1:0] regs_q [16];
    logic [DW-1:0] regs_d [16];
    logic          flag_q, flag_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0]    op;
    logic [3:0]    rn;
    logic [DW-1:0] r0, rv, imm, lg;
    logic [DW:0]   sum, dif, addi;
    logic          at_end, exec, taken, start;

    assign op     = instr[8:5];
    assign rn     = instr[4:1];
    assign r0     = regs_q[0];
    assign rv     = regs_q[rn];
    assign imm    = {{(DW-5){1'b0}}, instr[4:0]};
    assign sum    = {1'b0, r0} + {1'b0, rv};
    assign dif    = {1'b0, r0} - {1'b0, rv};
    assign addi   = {1'b0, r0} + {1'b0, imm};
    assign lg     = op == OP_AND ? r0 & rv : op == OP_OR ? r0 | rv : r0 ^ rv;
    // the end-of-program check precedes execute: the word at PROG_END never runs
    assign at_end = pc_q == PW'(PROG_END);
    assign exec   = state_q == RUN && !at_end;
    assign taken  = exec && (op == OP_JMP || (op == OP_BF && flag_q));
    assign start  = state_q == IDLE && req;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req ? RUN : IDLE;
            RUN:     state_d = (at_end || op == OP_HALT) ? DONE : RUN;
            DONE:    state_d = req ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done       = state_q == DONE;
        mem_we     = reset && exec && op == OP_ST;
        instr_addr = pc_q;
        mem_addr   = rv;
        mem_wdata  = r0;
        lut_idx    = instr[4:0];
        cycle_cnt  = cnt_q;
    end

    always_comb begin
        regs_d = regs_q;
        flag_d = flag_q;
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        if (start) begin
            regs_d = '{default: '0};
            flag_d = 1'b0;
            pc_d   = '0;
            cnt_d  = '0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q == '1 ? cnt_q : cnt_q + CW'(1);
            if (!at_end) begin
                pc_d = taken ? lut_target : op == OP_HALT ? pc_q : pc_q + PW'(1);
                case (op)
                    OP_LD:                 regs_d[0] = mem_rdata;
                    OP_MOVT:               regs_d[rn] = r0;
                    OP_MOVF:               regs_d[0] = rv;
                    OP_ADD:                {flag_d, regs_d[0]} = sum;
                    OP_SUB:                {flag_d, regs_d[0]} = dif;
                    OP_AND, OP_OR, OP_XOR: begin
                        regs_d[0] = lg;
                        flag_d    = lg == '0;
                    end
                    OP_SHL:                {flag_d, regs_d[0]} = {r0, 1'b0};
                    OP_SHR:                {regs_d[0], flag_d} = {1'b0, r0};
                    OP_LI:                 regs_d[0] = imm;
                    OP_ADDI:               {flag_d, regs_d[0]} = addi;
                    default:               ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q   <= '0;
            regs_q <= '{default: '0};
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_acc_core_ctl.sv
// tb_acc_core_ctl: directed programs against acc_core_ctl (PROG_END=20) plus a CW=4
// instance for counter saturation.
module tb_acc_core_ctl;
    logic        clk = 1'b0;
    logic        reset, req, req2;
    logic        done, done2, mem_we, mem_we2;
    logic [11:0] instr_addr, instr_addr2, lut_target, lut_target2;
    logic [8:0]  instr, instr2;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata, mem_addr2, mem_wdata2, mem_rdata2;
    logic [4:0]  lut_idx, lut_idx2;
    logic [15:0] cycle_cnt;
    logic [3:0]  cycle_cnt2;

    logic [8:0]  rom [0:4095];
    logic [8:0]  rom2 [0:15];
    logic [7:0]  dmem [0:255];
    int          wr_cnt = 0;
    logic [7:0]  last_addr = '0, last_data = '0;
    int          tests = 0, failed = 0;
    int          w0;

    always #5 clk = ~clk;

    acc_core_ctl #(.DW(8), .PW(12), .PROG_END(20), .CW(16)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .instr_addr(instr_addr),
        .instr(instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .lut_idx(lut_idx), .lut_target(lut_target), .cycle_cnt(cycle_cnt)
    );

    acc_core_ctl #(.DW(8), .PW(12), .PROG_END(100), .CW(4)) u_sat (
        .clk(clk), .reset(reset), .req(req2), .done(done2), .instr_addr(instr_addr2),
        .instr(instr2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2),
        .mem_rdata(mem_rdata2), .lut_idx(lut_idx2), .lut_target(lut_target2), .cycle_cnt(cycle_cnt2)
    );

    assign instr      = rom[instr_addr];
    assign instr2     = rom2[instr_addr2[3:0]];
    assign mem_rdata  = dmem[mem_addr];
    assign mem_rdata2 = 8'd0;

    always @(posedge clk) begin
        if (mem_we) begin
            dmem[mem_addr] <= mem_wdata;
            wr_cnt         <= wr_cnt + 1;
            last_addr      <= mem_addr;
            last_data      <= mem_wdata;
        end
    end

    function automatic logic [8:0] enc(input logic [3:0] op, input logic [4:0] f);
        return {op, f};
    endfunction

    function automatic logic [8:0] rg(input logic [3:0] op, input logic [3:0] rn);
        return {op, rn, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill(input logic [8:0] v);
        for (int i = 0; i < 4096; i++) rom[i] = v;
    endtask

    task automatic wait_done(input int max);
        int k;
        k = 0;
        while (done !== 1'b1 && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", {31'd0, done}, 1);
    endtask

    task automatic finish_run;
        req = 1'b0;
        step(1);
        chk("done_drop", {31'd0, done}, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 8'd0;
        for (int i = 0; i < 16; i++) rom2[i] = enc(4'd14, 5'd0);
        reset = 1'b0; req = 1'b0; req2 = 1'b0; lut_target = '0; lut_target2 = '0;
        fill(enc(4'd15, 5'd0));
        step(2);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_pc", {20'd0, instr_addr}, 0);
        chk("rst_cnt", {16'd0, cycle_cnt}, 0);
        reset = 1'b1;

        // reset mid-run with a store in flight
        fill(rg(4'd1, 4'd2));
        rom[0] = enc(4'd11, 5'd5);
        req = 1'b1;
        step(2);
        chk("st_in_flight", {31'd0, mem_we}, 1);
        w0 = wr_cnt;
        reset = 1'b0;
        #1 chk("rst_we_gate", {31'd0, mem_we}, 0);
        step(1);
        chk("rst_no_write", wr_cnt, w0);
        chk("rst_mid_done", {31'd0, done}, 0);
        chk("rst_mid_pc", {20'd0, instr_addr}, 0);
        chk("rst_mid_cnt", {16'd0, cycle_cnt}, 0);
        req = 1'b0;
        step(1);
        reset = 1'b1;
        step(3);
        chk("idle_pc", {20'd0, instr_addr}, 0);
        chk("idle_cnt", {16'd0, cycle_cnt}, 0);
        chk("idle_we", {31'd0, mem_we}, 0);

        // LI 31; ADDI 31; MOVT R1; ADD R1; ADD R1; ST R2; HALT
        fill(enc(4'd15, 5'd0));
        rom[0] = enc(4'd11, 5'd31); rom[1] = enc(4'd12, 5'd31); rom[2] = rg(4'd2, 4'd1);
        rom[3] = rg(4'd4, 4'd1); rom[4] = rg(4'd4, 4'd1); rom[5] = rg(4'd1, 4'd2);
        w0 = wr_cnt;
        req = 1'b1;
        wait_done(30);
        chk("p1_writes", wr_cnt - w0, 1);
        chk("p1_addr", {24'd0, last_addr}, 0);
        chk("p1_data", {24'd0, last_data}, 186);
        chk("p1_r0", {24'd0, mem_wdata}, 186);
        chk("p1_flag", {31'd0, dut.flag_q}, 0);
        chk("p1_cnt", {16'd0, cycle_cnt}, 7);
        finish_run();

        // shifts, taken and not-taken BF
        fill(enc(4'd15, 5'd0));
        rom[0] = enc(4'd11, 5'd31);
        for (int i = 1; i < 5; i++) rom[i] = enc(4'd9, 5'd0);
        rom[5] = enc(4'd13, 5'd7); rom[40] = rg(4'd7, 4'd1); rom[41] = enc(4'd13, 5'd7);
        lut_target = 12'd40;
        req = 1'b1;
        step(5);
        chk("shl3_r0", {24'd0, mem_wdata}, 248);
        chk("shl3_flag", {31'd0, dut.flag_q}, 0);
        step(1);
        chk("shl4_r0", {24'd0, mem_wdata}, 240);
        step(1);
        chk("bf_taken", {20'd0, instr_addr}, 40);
        step(2);
        chk("bf_not_taken", {20'd0, instr_addr}, 42);
        step(1);
        chk("p2_done", {31'd0, done}, 1);
        chk("p2_cnt", {16'd0, cycle_cnt}, 9);
        finish_run();

        // SUB borrow, SHR, LD, AND, XOR, MOVF, ADDI, ST
        fill(enc(4'd15, 5'd0));
        dmem[127] = 8'h5A;
        rom[0] = enc(4'd11, 5'd3); rom[1] = rg(4'd2, 4'd5); rom[2] = enc(4'd11, 5'd1);
        rom[3] = enc(4'd5, {4'd5, 1'b1}); rom[4] = enc(4'd13, 5'd0);
        rom[6] = enc(4'd10, 5'd0); rom[7] = rg(4'd2, 4'd3); rom[8] = rg(4'd0, 4'd3);
        rom[9] = rg(4'd6, 4'd5); rom[10] = rg(4'd8, 4'd3); rom[11] = rg(4'd3, 4'd5);
        rom[12] = enc(4'd12, 5'd31); rom[13] = rg(4'd1, 4'd3);
        lut_target = 12'd6;
        w0 = wr_cnt;
        req = 1'b1;
        wait_done(30);
        chk("p3_writes", wr_cnt - w0, 1);
        chk("p3_addr", {24'd0, last_addr}, 127);
        chk("p3_data", {24'd0, last_data}, 34);
        chk("p3_cnt", {16'd0, cycle_cnt}, 14);
        finish_run();

        // taken jump straight to PROG_END, then handshake
        fill(enc(4'd15, 5'd0));
        rom[0] = enc(4'd11, 5'd31); rom[1] = rg(4'd2, 4'd1);
        for (int i = 2; i < 5; i++) rom[i] = enc(4'd9, 5'd0);
        rom[5] = rg(4'd4, 4'd1); rom[6] = enc(4'd13, 5'd0); rom[20] = rg(4'd1, 4'd0);
        lut_target = 12'd20;
        w0 = wr_cnt;
        req = 1'b1;
        step(8);
        chk("jend_pc", {20'd0, instr_addr}, 20);
        chk("jend_not_done", {31'd0, done}, 0);
        chk("add_carry_r0", {24'd0, mem_wdata}, 23);
        step(1);
        chk("jend_done", {31'd0, done}, 1);
        chk("jend_cnt", {16'd0, cycle_cnt}, 8);
        chk("jend_no_write", wr_cnt - w0, 0);
        step(3);
        chk("hs_hold_done", {31'd0, done}, 1);
        chk("hs_hold_pc", {20'd0, instr_addr}, 20);
        chk("hs_hold_cnt", {16'd0, cycle_cnt}, 8);
        finish_run();
        rom[0] = enc(4'd13, 5'd0);
        lut_target = 12'd40;
        req = 1'b1;
        step(1);
        chk("rs_pc", {20'd0, instr_addr}, 0);
        chk("rs_cnt", {16'd0, cycle_cnt}, 0);
        chk("rs_r0", {24'd0, mem_wdata}, 0);
        step(1);
        chk("rs_flag_clear", {20'd0, instr_addr}, 1);
        wait_done(40);
        finish_run();

        // NOP program runs into PROG_END; the ST parked there never executes
        fill(rg(4'd2, 4'd0));
        rom[20] = rg(4'd1, 4'd0);
        w0 = wr_cnt;
        req = 1'b1;
        wait_done(40);
        chk("nop_pc", {20'd0, instr_addr}, 20);
        chk("nop_cnt", {16'd0, cycle_cnt}, 21);
        chk("nop_no_write", wr_cnt - w0, 0);
        finish_run();

        // HALT just before PROG_END
        rom[19] = enc(4'd15, 5'd0);
        req = 1'b1;
        wait_done(40);
        chk("halt19_pc", {20'd0, instr_addr}, 19);
        chk("halt19_cnt", {16'd0, cycle_cnt}, 20);
        finish_run();

        // CW=4 counter saturation on a self-jump
        req2 = 1'b1;
        step(20);
        chk("sat_cnt", {28'd0, cycle_cnt2}, 15);
        chk("sat_not_done", {31'd0, done2}, 0);
        step(5);
        chk("sat_hold", {28'd0, cycle_cnt2}, 15);
        chk("sat_pc", {20'd0, instr_addr2}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
